// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - request/response sequencer driving the combinational datapath ALU, MUL as shift-add loop
// Optional build macro: ALU_SEQ_MUL_EARLY_EXIT_EN (MUL loop stops once the remaining multiplier is exhausted).
module alu_sequencer #(
  parameter int WIDTH = 21
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ReqValid,
  output logic             ReqReady,
  input  logic [2:0]       ReqOp,
  input  logic [WIDTH-1:0] ReqA,
  input  logic [WIDTH-1:0] ReqB,
  output logic             RspValid,
  input  logic             RspReady,
  output logic [WIDTH-1:0] RspResult,
  output logic             RspZero,
  output logic [WIDTH-1:0] AluA,
  output logic [WIDTH-1:0] AluB,
  output logic [2:0]       AluControl,
  input  logic [WIDTH-1:0] AluResult,
  input  logic             AluZero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_EQ  = 3'b110;

  typedef enum logic [1:0] {IDLE, EXEC, MUL_LOOP, RESP} state_t;

  state_t          state, state_nxt;
  logic [2:0]      op_q;
  // mc/mp double as the latched A/B operands for single-step ops
  logic [WIDTH-1:0] acc, mc, mp;
  logic [CW-1:0]    cnt;
  logic             mul_done;

`ifdef ALU_SEQ_MUL_EARLY_EXIT_EN
  assign mul_done = (cnt == LAST_ITER) || ((mp >> 1) == '0);
`else
  assign mul_done = (cnt == LAST_ITER);
`endif

  assign ReqReady = (state == IDLE);
  assign RspValid = (state == RESP);
  assign RspZero  = (RspResult == '0);

  always_comb begin
    state_nxt  = state;
    AluA       = '0;
    AluB       = '0;
    AluControl = OP_ADD;
    case (state)
      IDLE: begin
        if (ReqValid) state_nxt = (ReqOp == OP_MUL) ? MUL_LOOP : EXEC;
      end
      EXEC: begin
        AluA       = mc;
        AluB       = mp;
        AluControl = (op_q == OP_EQ) ? OP_SUB : op_q;
        state_nxt  = RESP;
      end
      MUL_LOOP: begin
        AluA = acc;
        AluB = mp[0] ? mc : '0;
        if (mul_done) state_nxt = RESP;
      end
      RESP: begin
        if (RspReady) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= '0;
      acc       <= '0;
      mc        <= '0;
      mp        <= '0;
      cnt       <= '0;
      RspResult <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (ReqValid) begin
            op_q <= ReqOp;
            mc   <= ReqA;
            mp   <= ReqB;
            acc  <= '0;
            cnt  <= '0;
          end
        end
        EXEC: begin
          // EQ is a subtract whose zero flag becomes the 0/1 result
          RspResult <= (op_q == OP_EQ) ? {{(WIDTH-1){1'b0}}, AluZero} : AluResult;
        end
        MUL_LOOP: begin
          acc <= AluResult;
          mc  <= mc << 1;
          mp  <= mp >> 1;
          cnt <= cnt + CW'(1);
          if (mul_done) RspResult <= AluResult;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer with a behavioural ALU and reference model
module tb_alu_sequencer;

  localparam int W = 21;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ReqValid, ReqReady, RspValid, RspReady, RspZero, AluZero;
  logic [2:0]    ReqOp, AluControl;
  logic [W-1:0]  ReqA, ReqB, RspResult, AluA, AluB, AluResult;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqOp(ReqOp), .ReqA(ReqA), .ReqB(ReqB),
    .RspValid(RspValid), .RspReady(RspReady), .RspResult(RspResult), .RspZero(RspZero),
    .AluA(AluA), .AluB(AluB), .AluControl(AluControl),
    .AluResult(AluResult), .AluZero(AluZero)
  );

  // Stand-in for the datapath ALU the sequencer drives
  always_comb begin
    AluResult = '0;
    case (AluControl)
      3'd0: AluResult = AluA + AluB;
      3'd1: AluResult = AluA - AluB;
      3'd2: AluResult = AluA & AluB;
      3'd3: AluResult = AluA | AluB;
      3'd4: AluResult = (AluB >= W) ? '0 : (AluA << AluB);
      default: AluResult = '0;
    endcase
  end
  assign AluZero = (AluResult == '0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_result(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned x, la, lb;
    la = longint'(a);
    lb = longint'(b);
    case (op)
      3'd0: x = la + lb;
      3'd1: x = la - lb;
      3'd2: x = la & lb;
      3'd3: x = la | lb;
      3'd4: x = (lb >= W) ? 0 : (la << lb);
      3'd5: x = la * lb;
      3'd6: x = (a == b) ? 1 : 0;
      default: x = 0;
    endcase
    return x[W-1:0];
  endfunction

  // Cycles from the accepting edge to the edge after which RspValid is high
  function automatic int ref_lat(input logic [2:0] op, input logic [W-1:0] b);
    int n;
    if (op != 3'd5) return 1;
`ifdef ALU_SEQ_MUL_EARLY_EXIT_EN
    n = 0;
    while (n < W && (b >> n) != 0) n++;
    return (n < 1) ? 1 : n;
`else
    return W;
`endif
  endfunction

  task automatic do_op(input string tag, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] er;
    int lat;
    er = ref_result(op, a, b);
    @(negedge clk);
    chk({tag, "/ready"}, 32'(ReqReady), 32'd1);
    ReqValid = 1'b1; ReqOp = op; ReqA = a; ReqB = b;
    @(posedge clk);
    #1 ReqValid = 1'b0;
    @(negedge clk);
    chk({tag, "/aluctl"}, 32'(AluControl), (op == 3'd6) ? 32'd1 : (op == 3'd5) ? 32'd0 : 32'(op));
    lat = 0;
    while (!RspValid && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, "/latency"}, 32'(lat), 32'(ref_lat(op, b)));
    chk({tag, "/result"}, 32'(RspResult), 32'(er));
    chk({tag, "/zero"}, 32'(RspZero), 32'(er == '0));
    RspReady = 1'b1;
    @(posedge clk);
    #1 RspReady = 1'b0;
    @(negedge clk);
    chk({tag, "/valid_drop"}, 32'(RspValid), 32'd0);
  endtask

  initial begin
    logic [2:0]   op;
    logic [W-1:0] a, b;
    bit           saw;

    rst_n = 1'b0; ReqValid = 1'b0; ReqOp = '0; ReqA = '0; ReqB = '0; RspReady = 1'b0;
    #12;
    chk("rst/ready", 32'(ReqReady), 32'd1);
    chk("rst/valid", 32'(RspValid), 32'd0);
    chk("rst/result", 32'(RspResult), 32'd0);
    chk("rst/zero", 32'(RspZero), 32'd1);
    chk("rst/alu", {AluControl, 8'd0, AluA}, 32'd0);
    chk("rst/alub", 32'(AluB), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("add_wrap", 3'd0, 21'h1FFFFF, 21'h000001);
    do_op("sub", 3'd1, 21'd10, 21'd3);
    do_op("eq_same", 3'd6, 21'd5, 21'd5);
    do_op("eq_diff", 3'd6, 21'd5, 21'd6);
    do_op("mul_1000", 3'd5, 21'd1000, 21'd1000);
    do_op("mul_trunc", 3'd5, 21'h1000, 21'h1000);
    do_op("mul_zero", 3'd5, 21'd7, 21'd0);
    do_op("mul_b5", 3'd5, 21'd9, 21'd5);
    do_op("sll_big", 3'd4, 21'd3, 21'd21);
    do_op("rsvd", 3'd7, 21'd12, 21'd34);

    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = W'($urandom);
      b  = W'($urandom);
      if (op == 3'd4) b = W'($urandom_range(0, 24));
      if (op == 3'd6 && $urandom_range(0, 1) == 1) b = a;
      if (op == 3'd5 && $urandom_range(0, 1) == 1) b = W'($urandom_range(0, 300));
      do_op($sformatf("rand%0d_op%0d", i, op), op, a, b);
    end

    // Back-pressure with a second request held pending
    @(negedge clk);
    ReqValid = 1'b1; ReqOp = 3'd0; ReqA = 21'd2; ReqB = 21'd2;
    @(posedge clk);
    #1 ReqA = 21'd3; ReqB = 21'd3;
    @(negedge clk);
    chk("bp/ready_exec", 32'(ReqReady), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp/valid%0d", k), 32'(RspValid), 32'd1);
      chk($sformatf("bp/result%0d", k), 32'(RspResult), 32'd4);
      chk($sformatf("bp/ready%0d", k), 32'(ReqReady), 32'd0);
    end
    RspReady = 1'b1;
    @(posedge clk);
    #1 RspReady = 1'b0;
    @(negedge clk);
    chk("bp/valid_drop", 32'(RspValid), 32'd0);
    chk("bp/ready_idle", 32'(ReqReady), 32'd1);
    @(posedge clk);
    #1 ReqValid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("bp/second_valid", 32'(RspValid), 32'd1);
    chk("bp/second_result", 32'(RspResult), 32'd6);
    RspReady = 1'b1;
    @(posedge clk);
    #1 RspReady = 1'b0;

    // Reset during MUL iteration 10
    @(negedge clk);
    ReqValid = 1'b1; ReqOp = 3'd5; ReqA = 21'd1000; ReqB = 21'd1000;
    @(posedge clk);
    #1 ReqValid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("abort/in_loop", 32'(ReqReady), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort/ready", 32'(ReqReady), 32'd1);
    chk("abort/valid", 32'(RspValid), 32'd0);
    chk("abort/result", 32'(RspResult), 32'd0);
    chk("abort/zero", 32'(RspZero), 32'd1);
    chk("abort/alua", 32'(AluA), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (RspValid) saw = 1'b1;
    end
    chk("abort/no_rsp", 32'(saw), 32'd0);
    do_op("after_abort", 3'd0, 21'd1, 21'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
